// File: rtl/data_router_if.sv
// data_router_if
//   Bundles the byte-input, key, data-FIFO and error signals of data_router.
//   The router itself sits on the slave modport. The master modport is used
//   by whatever drives the router: the handshake reader, the cipher core and
//   the interface FSM, or a testbench standing in for all three.
//
//   Byte input  : in_byte, in_is_key, in_pulse  (master -> slave)
//   Error clear : err_clear                     (master -> slave)
//   Key         : key_out, key_valid, key_load_pulse, key_pending (slave -> master)
//   Data FIFO   : data_out, data_valid, fifo_count, fifo_full (slave -> master),
//                 data_ready (master -> slave)
//   Errors      : overflow_err, nokey_err       (slave -> master)
interface data_router_if #(
  parameter int KEY_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]             in_byte;
  logic                   in_is_key;
  logic                   in_pulse;
  logic                   err_clear;
  logic [8*KEY_BYTES-1:0] key_out;
  logic                   key_valid;
  logic                   key_load_pulse;
  logic                   key_pending;
  logic [7:0]             data_out;
  logic                   data_valid;
  logic                   data_ready;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   overflow_err;
  logic                   nokey_err;

  modport slave (
    input  in_byte, in_is_key, in_pulse, err_clear, data_ready,
    output key_out, key_valid, key_load_pulse, key_pending,
           data_out, data_valid, fifo_count, fifo_full,
           overflow_err, nokey_err
  );

  modport master (
    output in_byte, in_is_key, in_pulse, err_clear, data_ready,
    input  key_out, key_valid, key_load_pulse, key_pending,
           data_out, data_valid, fifo_count, fifo_full,
           overflow_err, nokey_err
  );
endinterface

// File: rtl/data_router.sv
// data_router
//   Steers single-cycle byte pulses from the handshake reader.
//   - Key bytes shift into a key register. Once KEY_BYTES bytes have arrived,
//     the assembled word is published on key_out. The first byte received
//     ends up in the MSBs.
//   - Data bytes go into a small show-ahead FIFO that the cipher core drains
//     with valid/ready. A data byte is accepted only after a key exists.
//   - Dropped data bytes set sticky error flags, which err_clear clears.
//
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous, active-high reset
//     bus : data_router_if.slave (byte input, key, FIFO and error signals)
//
//   Every output comes from a register or from the FIFO storage. There is no
//   combinational path from in_* to any output.
module data_router #(
  parameter int KEY_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  data_router_if.slave  bus
);

  localparam int KW  = 8 * KEY_BYTES;
  localparam int KCW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------- key path
  logic [KW-1:0]  key_shift_reg;
  logic [KW-1:0]  key_out_reg;
  logic [KW-1:0]  key_word;
  logic [KCW-1:0] key_cnt_reg;
  logic           key_valid_reg;
  logic           key_load_reg;
  logic           key_byte;
  logic           key_last;

  assign key_byte = bus.in_pulse && bus.in_is_key;
  assign key_last = (key_cnt_reg == KCW'(KEY_BYTES - 1));

  // The shift word includes the incoming byte. The final byte of a key is
  // therefore already part of the word published on key_out.
  generate
    if (KEY_BYTES == 1) begin : g_key_single
      assign key_word = bus.in_byte;
    end else begin : g_key_multi
      assign key_word = {key_shift_reg[KW-9:0], bus.in_byte};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_shift_reg <= '0;
      key_out_reg   <= '0;
      key_cnt_reg   <= '0;
      key_valid_reg <= 1'b0;
      key_load_reg  <= 1'b0;
    end else begin
      key_load_reg <= 1'b0;
      if (key_byte) begin
        key_shift_reg <= key_word;
        if (key_last) begin
          key_cnt_reg   <= '0;
          key_out_reg   <= key_word;
          key_valid_reg <= 1'b1;
          key_load_reg  <= 1'b1;
        end else begin
          key_cnt_reg <= key_cnt_reg + KCW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------- data FIFO
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [7:0]    mem_rd [FIFO_DEPTH];
  logic          data_byte;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          nokey_evt;
  logic          ovf_evt;

  assign data_byte = bus.in_pulse && !bus.in_is_key;
  assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = (count_reg != '0) && bus.data_ready;
  // A full FIFO still accepts a byte when a pop frees the head entry on the
  // same edge. Routing uses the registered key_valid, so the byte that
  // completes a key cannot let a data byte through on the same edge.
  assign push      = data_byte && key_valid_reg && (!fifo_full || pop);
  assign nokey_evt = data_byte && !key_valid_reg;
  assign ovf_evt   = data_byte && key_valid_reg && fifo_full && !pop;

  // One register per entry, all cleared on reset, so that data_out reads 0
  // after reset.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      logic [7:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          entry_reg <= bus.in_byte;
        end
      end
      assign mem_rd[gi] = entry_reg;
    end
  endgenerate

  // FIFO_DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------ sticky errors
  logic ovf_reg;
  logic nokey_reg;

  // A new error event takes priority over err_clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg   <= 1'b0;
      nokey_reg <= 1'b0;
    end else begin
      if (ovf_evt)            ovf_reg   <= 1'b1;
      else if (bus.err_clear) ovf_reg   <= 1'b0;
      if (nokey_evt)          nokey_reg <= 1'b1;
      else if (bus.err_clear) nokey_reg <= 1'b0;
    end
  end

  // ------------------------------------------------------------------ outputs
  assign bus.key_out        = key_out_reg;
  assign bus.key_valid      = key_valid_reg;
  assign bus.key_load_pulse = key_load_reg;
  assign bus.key_pending    = (key_cnt_reg != '0);
  assign bus.data_out       = mem_rd[rd_ptr_reg];
  assign bus.data_valid     = (count_reg != '0);
  assign bus.fifo_count     = count_reg;
  assign bus.fifo_full      = fifo_full;
  assign bus.overflow_err   = ovf_reg;
  assign bus.nokey_err      = nokey_reg;

endmodule

// File: doc/data_router.md
Name: data_router

Overview:
- Consumes the single-cycle byte pulses produced by the handshake reader and steers each byte by its key flag.
- Key bytes are assembled into a full-width key register that the cipher core loads.
- Data bytes are buffered in a small show-ahead FIFO drained by the cipher core over a valid/ready interface.
- Flags sticky error conditions so the interface FSM can report them to the host.

Parameters:
- KEY_BYTES, 4, number of bytes in one complete key (>=1).
- FIFO_DEPTH, 4, data FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_byte  input  8  byte qualified by in_pulse.
- in_is_key  input  1  1 = key byte, 0 = data byte; qualified by in_pulse.
- in_pulse  input  1  single-cycle strobe; one byte per high cycle.
- err_clear  input  1  clears sticky error flags.
- key_out  output  8*KEY_BYTES  last complete key; first byte received ends up in the MSBs.
- key_valid  output  1  at least one complete key has been assembled since reset.
- key_load_pulse  output  1  one-cycle strobe when key_out takes a new key.
- key_pending  output  1  partial key in progress (byte count != 0).
- data_out  output  8  FIFO head byte.
- data_valid  output  1  FIFO not empty.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- overflow_err  output  1  sticky: data byte dropped because the FIFO was full.
- nokey_err  output  1  sticky: data byte dropped because key_valid was 0.

Behaviour:
- Reset (rst high, async): key shift register, key_out, byte counter, FIFO pointers and count all 0. key_valid, key_load_pulse, key_pending, data_valid, fifo_full, overflow_err and nokey_err are all 0. data_out reads 0.
- Key path:
  - On in_pulse && in_is_key, shift: key_shift <= {key_shift[8*KEY_BYTES-9:0], in_byte}; byte counter increments.
  - When the counter equals KEY_BYTES-1 at the pulse, the next-edge outputs are: key_out <= assembled word including this byte; key_valid <= 1; key_load_pulse high for exactly that one cycle; counter wraps to 0.
  - key_out holds its previous value throughout a partial reload.
  - key_valid never falls except on reset.
  - KEY_BYTES=1: every key byte is a complete key.
- Data path, on in_pulse && !in_is_key:
  - key_valid==0: byte dropped; nokey_err <= 1.
  - FIFO full and no pop this cycle: byte dropped; overflow_err <= 1.
  - Otherwise: byte written at the write pointer.
  - A data byte does not affect the key byte counter. A partial key stays pending; data routing uses the old key_valid.
- FIFO:
  - Show-ahead: data_out = mem[rd_ptr] combinationally; data_valid = (count != 0).
  - Pop when data_valid && data_ready.
  - Simultaneous push and pop: count unchanged. This is permitted when full; the push is accepted and no overflow is flagged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - A pulse at edge N is visible at N+1 on data_valid / fifo_count / key_out / key_load_pulse.
  - No combinational path from in_* to any output.
- Errors:
  - err_clear clears both sticky flags at the next edge.
  - If a new error event coincides with err_clear, set wins.
- The reader guarantees in_pulse is never high on consecutive cycles; the block still accepts back-to-back pulses correctly, one byte per cycle.

Test Plan:
- Reset, then key bytes 0x11,0x22,0x33,0x44 (KEY_BYTES=4) -> key_pending=1 after the first byte; key_out=0x11223344 and key_valid=1 one cycle after the 4th pulse; key_load_pulse high exactly one cycle.
- Data byte 0xAA before any key -> FIFO stays empty, nokey_err=1. Then err_clear -> nokey_err=0.
- With key loaded and data_ready=0, send 0x01..0x05 -> fifo_count=4, fifo_full=1, 0x05 dropped, overflow_err=1. Then raise data_ready -> data_out sequence 0x01,0x02,0x03,0x04, then data_valid=0.
- Full FIFO, data_ready=1 and a data pulse 0x77 on the same cycle -> count stays 4, overflow_err stays 0, 0x77 emerges last.
- Key reload interleaved with data: 2 key bytes 0x55,0x66, data 0x99, 2 key bytes 0x77,0x88 -> 0x99 is queued under the old key; key_out changes only after the 4th key byte, to 0x55667788.
- Assert rst mid-transfer (FIFO holding 2 bytes, key half-loaded) -> all outputs 0 immediately, without waiting for a clock edge. The next key requires 4 fresh bytes.
